// File: rtl/ray_dir_reciprocal.sv
// Per-axis reciprocal of a ray direction (Q16.16 in, Q18.18 out) using one shared
// serial restoring divider; feeds the ray/box slab test.
module ray_dir_reciprocal #(
    parameter int unsigned DIR_W    = 32,
    parameter int unsigned DIR_FRAC = 16,
    parameter int unsigned INV_W    = 36,
    parameter int unsigned INV_FRAC = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*DIR_W-1:0]   ray_orig_in,
    input  logic [3*DIR_W-1:0]   ray_dir_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*DIR_W-1:0]   ray_orig,
    output logic [3*INV_W-1:0]   inv_ray_dir,
    output logic [2:0]           div_by_zero,
    output logic                 busy
);

    localparam int unsigned QW    = DIR_FRAC + INV_FRAC + 1;
    localparam int unsigned CNT_W = $clog2(QW);
    localparam int unsigned CMP_W = (QW > INV_W) ? QW : INV_W;
    localparam int unsigned REM_W = DIR_W + 1;

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(QW - 1);
    localparam logic [CMP_W-1:0] MAX_POS   = (CMP_W'(1) << (INV_W - 1)) - CMP_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [3*DIR_W-1:0]   dir_q, dir_d;
    logic [DIR_W-1:0]     divisor_q, divisor_d;
    logic                 neg_q, neg_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic [QW-1:0]        quot_q, quot_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3*DIR_W-1:0]   orig_d;
    logic [3*INV_W-1:0]   inv_d;
    logic [2:0]           dbz_d;

    logic [DIR_W-1:0]     cur_dir;
    logic [DIR_W-1:0]     abs_dir;
    logic                 dbit;
    logic [REM_W:0]       rem_sh;
    logic                 ge;
    logic [REM_W:0]       rem_sub;
    logic [QW-1:0]        quot_nx;
    logic [CMP_W-1:0]     q_ext;
    logic [CMP_W-1:0]     mag;
    logic [INV_W-1:0]     mag_w;
    logic [INV_W-1:0]     res;

    // Divider datapath: one restoring step on the implicit dividend 2^(QW-1)
    always_comb begin
        cur_dir = '0;
        case (idx_q)
            2'd0:    cur_dir = dir_q[0*DIR_W +: DIR_W];
            2'd1:    cur_dir = dir_q[1*DIR_W +: DIR_W];
            2'd2:    cur_dir = dir_q[2*DIR_W +: DIR_W];
            default: cur_dir = '0;
        endcase
        abs_dir = cur_dir[DIR_W-1] ? (~cur_dir + 1'b1) : cur_dir;
        dbit    = (cnt_q == CNT_START);
        rem_sh  = {rem_q, dbit};
        ge      = (rem_sh >= (REM_W+1)'(divisor_q));
        rem_sub = ge ? (rem_sh - (REM_W+1)'(divisor_q)) : rem_sh;
        quot_nx = QW'({quot_q, ge});
        q_ext   = CMP_W'(quot_nx);
        mag     = (q_ext > MAX_POS) ? MAX_POS : q_ext;
        mag_w   = INV_W'(mag);
        res     = neg_q ? (~mag_w + 1'b1) : mag_w;
    end

    // Next-state and register-next logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dir_d     = dir_q;
        divisor_d = divisor_q;
        neg_d     = neg_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        cnt_d     = cnt_q;
        orig_d    = ray_orig;
        inv_d     = inv_ray_dir;
        dbz_d     = div_by_zero;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    orig_d = ray_orig_in;
                    dir_d  = ray_dir_in;
                    for (int i = 0; i < 3; i++) begin
                        dbz_d[i] = (ray_dir_in[i*DIR_W +: DIR_W] == '0);
                    end
                    idx_d   = '0;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end else if (cur_dir == '0) begin
                    for (int i = 0; i < 3; i++) begin
                        if (idx_q == 2'(i)) inv_d[i*INV_W +: INV_W] = '0;
                    end
                    idx_d = idx_q + 2'd1;
                end else begin
                    divisor_d = abs_dir;
                    neg_d     = cur_dir[DIR_W-1];
                    rem_d     = '0;
                    quot_d    = '0;
                    cnt_d     = CNT_START;
                    state_d   = DIV;
                end
            end
            DIV: begin
                rem_d  = REM_W'(rem_sub);
                quot_d = quot_nx;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    for (int i = 0; i < 3; i++) begin
                        if (idx_q == 2'(i)) inv_d[i*INV_W +: INV_W] = res;
                    end
                    idx_d   = idx_q + 2'd1;
                    state_d = SEL;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dir_q       <= '0;
            divisor_q   <= '0;
            neg_q       <= 1'b0;
            rem_q       <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            ray_orig    <= '0;
            inv_ray_dir <= '0;
            div_by_zero <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            divisor_q   <= divisor_d;
            neg_q       <= neg_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            cnt_q       <= cnt_d;
            ray_orig    <= orig_d;
            inv_ray_dir <= inv_d;
            div_by_zero <= dbz_d;
            out_valid   <= (state_d == DONE);
            busy        <= (state_d != IDLE);
            in_ready    <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_ray_dir_reciprocal.sv
// Scoreboard bench for ray_dir_reciprocal: expectations queued at accept, checked at output.
module tb_ray_dir_reciprocal;

    localparam int unsigned DIR_W = 32;
    localparam int unsigned INV_W = 36;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [3*DIR_W-1:0] ray_orig_in;
    logic [3*DIR_W-1:0] ray_dir_in;
    logic               out_valid;
    logic               out_ready;
    logic [3*DIR_W-1:0] ray_orig;
    logic [3*INV_W-1:0] inv_ray_dir;
    logic [2:0]         div_by_zero;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [3*DIR_W-1:0] orig;
        logic [3*INV_W-1:0] inv;
        logic [2:0]         dbz;
    } exp_t;

    exp_t exp_q[$];

    ray_dir_reciprocal dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ray_orig_in (ray_orig_in),
        .ray_dir_in  (ray_dir_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ray_orig    (ray_orig),
        .inv_ray_dir (inv_ray_dir),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: trunc(2^34 / |d|) * sign(d), saturated to the signed output range
    function automatic logic [INV_W-1:0] model_inv(input logic [DIR_W-1:0] d);
        longint mag;
        longint q;
        if (d == '0) return '0;
        mag = longint'($signed(d));
        if (mag < 0) mag = -mag;
        q = (longint'(1) << 34) / mag;
        if (q > ((longint'(1) << 35) - 1)) q = (longint'(1) << 35) - 1;
        if (d[DIR_W-1]) q = -q;
        return INV_W'(q);
    endfunction

    function automatic exp_t model_ray(input logic [3*DIR_W-1:0] o, input logic [3*DIR_W-1:0] d);
        exp_t r;
        r.orig = o;
        r.inv  = '0;
        r.dbz  = '0;
        for (int i = 0; i < 3; i++) begin
            r.inv[i*INV_W +: INV_W] = model_inv(d[i*DIR_W +: DIR_W]);
            r.dbz[i] = (d[i*DIR_W +: DIR_W] == '0);
        end
        return r;
    endfunction

    function automatic logic [DIR_W-1:0] rand_comp();
        logic [DIR_W-1:0] v;
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = ~v + 1'b1;
        if (v == '0) v = 1;
        return v;
    endfunction

    // Present a ray and hold it until accepted; queue its expectation at the accept edge
    task automatic send_ray(input logic [3*DIR_W-1:0] o, input logic [3*DIR_W-1:0] d,
                            input exp_t e, output int acc);
        ray_orig_in = o;
        ray_dir_in  = d;
        in_valid    = 1'b1;
        acc         = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
                exp_q.push_back(e);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int seen);
        seen = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL reset_flags: got valid/busy/ready=%b want 001", {out_valid, busy, in_ready});
        end
        n_vec++;
        if (inv_ray_dir !== '0 || div_by_zero !== 3'b000 || ray_orig !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got inv=%h dbz=%b orig=%h want all zero",
                     inv_ray_dir, div_by_zero, ray_orig);
        end
    endtask

    task automatic test_single_axis();
        exp_t e;
        int acc, seen;
        e.orig = '0;
        e.inv  = {72'd0, 36'(64'd1 << 18)};
        e.dbz  = 3'b110;
        out_ready = 1'b1;
        send_ray('0, {64'd0, 32'(32'd1 << 16)}, e, acc);
        wait_valid(seen);
        n_vec++;
        if (acc < 0 || seen < 0 || seen - acc != 39) begin
            n_err++;
            $display("FAIL single_latency: got %0d want 39", seen - acc);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL single_result: got no queued ray want one");
        end else begin
            e = exp_q.pop_front();
            if ({ray_orig, inv_ray_dir, div_by_zero} !== {e.orig, e.inv, e.dbz}) begin
                n_err++;
                $display("FAIL single_result: got orig=%h inv=%h dbz=%b want orig=%h inv=%h dbz=%b",
                         ray_orig, inv_ray_dir, div_by_zero, e.orig, e.inv, e.dbz);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mixed();
        exp_t e;
        int acc, seen;
        logic [3*DIR_W-1:0] o;
        o      = {32'h0001_2345, 32'hFFFF_0000, 32'h7FFF_FFFF};
        e.orig = o;
        e.inv  = {36'(64'd1 << 34), 36'd87381, 36'(-64'sd131072)};
        e.dbz  = 3'b000;
        out_ready = 1'b1;
        send_ray(o, {32'd1, 32'(3 << 16), 32'(-(1 << 17))}, e, acc);
        wait_valid(seen);
        n_vec++;
        if (acc < 0 || seen < 0 || seen - acc != 109) begin
            n_err++;
            $display("FAIL mixed_latency: got %0d want 109", seen - acc);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL mixed_result: got no queued ray want one");
        end else begin
            e = exp_q.pop_front();
            if ({ray_orig, inv_ray_dir, div_by_zero} !== {e.orig, e.inv, e.dbz}) begin
                n_err++;
                $display("FAIL mixed_result: got orig=%h inv=%h dbz=%b want orig=%h inv=%h dbz=%b",
                         ray_orig, inv_ray_dir, div_by_zero, e.orig, e.inv, e.dbz);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_min_neg();
        exp_t e;
        int acc, seen;
        e.orig = {32'd3, 32'd2, 32'd1};
        e.inv  = {72'd0, 36'(-64'sd8)};
        e.dbz  = 3'b110;
        out_ready = 1'b1;
        send_ray(e.orig, {64'd0, 32'h8000_0000}, e, acc);
        wait_valid(seen);
        n_vec++;
        if (acc < 0 || seen < 0 || seen - acc != 39) begin
            n_err++;
            $display("FAIL minneg_latency: got %0d want 39", seen - acc);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL minneg_result: got no queued ray want one");
        end else begin
            e = exp_q.pop_front();
            if ({ray_orig, inv_ray_dir, div_by_zero} !== {e.orig, e.inv, e.dbz}) begin
                n_err++;
                $display("FAIL minneg_result: got orig=%h inv=%h dbz=%b want orig=%h inv=%h dbz=%b",
                         ray_orig, inv_ray_dir, div_by_zero, e.orig, e.inv, e.dbz);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_zero();
        exp_t e;
        int acc, seen;
        e.orig = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678};
        e.inv  = '0;
        e.dbz  = 3'b111;
        out_ready = 1'b1;
        send_ray(e.orig, '0, e, acc);
        wait_valid(seen);
        n_vec++;
        if (acc < 0 || seen < 0 || seen - acc != 4) begin
            n_err++;
            $display("FAIL zero_latency: got %0d want 4", seen - acc);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL zero_result: got no queued ray want one");
        end else begin
            e = exp_q.pop_front();
            if ({ray_orig, inv_ray_dir, div_by_zero} !== {e.orig, e.inv, e.dbz}) begin
                n_err++;
                $display("FAIL zero_result: got orig=%h inv=%h dbz=%b want orig=%h inv=%h dbz=%b",
                         ray_orig, inv_ray_dir, div_by_zero, e.orig, e.inv, e.dbz);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_div();
        exp_t e;
        int acc, seen;
        logic [3*DIR_W-1:0] o;
        logic [3*DIR_W-1:0] d;
        o = {32'd7, 32'd8, 32'd9};
        d = {64'd0, 32'(5 << 16)};
        out_ready = 1'b1;
        send_ray(o, d, model_ray(o, d), acc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL middiv_flags: got valid/busy/ready=%b want 001", {out_valid, busy, in_ready});
        end
        n_vec++;
        if (inv_ray_dir !== '0 || div_by_zero !== 3'b000 || ray_orig !== '0) begin
            n_err++;
            $display("FAIL middiv_outputs: got inv=%h dbz=%b orig=%h want all zero",
                     inv_ray_dir, div_by_zero, ray_orig);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL middiv_ready: got %b want 1", in_ready);
        end
        e.orig = {32'd4, 32'd5, 32'd6};
        e.inv  = {36'(-64'sd65536), 36'd0, 36'd131072};
        e.dbz  = 3'b010;
        send_ray(e.orig, {32'(-(4 << 16)), 32'd0, 32'(2 << 16)}, e, acc);
        wait_valid(seen);
        n_vec++;
        if (acc < 0 || seen < 0 || seen - acc != 74) begin
            n_err++;
            $display("FAIL middiv_latency: got %0d want 74", seen - acc);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL middiv_result: got no queued ray want one");
        end else begin
            e = exp_q.pop_front();
            if ({ray_orig, inv_ray_dir, div_by_zero} !== {e.orig, e.inv, e.dbz}) begin
                n_err++;
                $display("FAIL middiv_result: got orig=%h inv=%h dbz=%b want orig=%h inv=%h dbz=%b",
                         ray_orig, inv_ray_dir, div_by_zero, e.orig, e.inv, e.dbz);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        exp_t ea, eb;
        int acc, seen;
        logic [3*DIR_W-1:0] oa, da, ob, db;
        oa = {32'd11, 32'd22, 32'd33};
        da = {32'd0, 32'(-7), 32'(3 << 16)};
        ob = {32'hAAAA_0000, 32'h5555_0000, 32'h0F0F_0F0F};
        db = {32'(-(1 << 20)), 32'd12345, 32'(9 << 16)};
        ea = model_ray(oa, da);
        out_ready = 1'b0;
        send_ray(oa, da, ea, acc);
        wait_valid(seen);
        n_vec++;
        if (acc < 0 || seen < 0 || seen - acc != 74) begin
            n_err++;
            $display("FAIL bp_latency_a: got %0d want 74", seen - acc);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bp_result_a: got no queued ray want one");
        end else begin
            ea = exp_q.pop_front();
            if ({ray_orig, inv_ray_dir, div_by_zero} !== {ea.orig, ea.inv, ea.dbz}) begin
                n_err++;
                $display("FAIL bp_result_a: got orig=%h inv=%h dbz=%b want orig=%h inv=%h dbz=%b",
                         ray_orig, inv_ray_dir, div_by_zero, ea.orig, ea.inv, ea.dbz);
            end
        end
        ray_orig_in = ob;
        ray_dir_in  = db;
        in_valid    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {ray_orig, inv_ray_dir, div_by_zero} !== {ea.orig, ea.inv, ea.dbz}) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d got valid=%b ready=%b inv=%h want valid=1 ready=0 inv=%h",
                         k, out_valid, in_ready, inv_ray_dir, ea.inv);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc = cyc;
        exp_q.push_back(model_ray(ob, db));
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept_b: got busy=%b ready=%b want busy=1 ready=0", busy, in_ready);
        end
        wait_valid(seen);
        n_vec++;
        if (seen < 0 || seen - acc != 109) begin
            n_err++;
            $display("FAIL bp_latency_b: got %0d want 109", seen - acc);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bp_result_b: got no queued ray want one");
        end else begin
            eb = exp_q.pop_front();
            if ({ray_orig, inv_ray_dir, div_by_zero} !== {eb.orig, eb.inv, eb.dbz}) begin
                n_err++;
                $display("FAIL bp_result_b: got orig=%h inv=%h dbz=%b want orig=%h inv=%h dbz=%b",
                         ray_orig, inv_ray_dir, div_by_zero, eb.orig, eb.inv, eb.dbz);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int got;
        int acc;
        exp_t e, r;
        logic [3*DIR_W-1:0] o, d;
        got = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    o = {32'($urandom), 32'($urandom), 32'($urandom)};
                    d = {rand_comp(), rand_comp(), rand_comp()};
                    e = model_ray(o, d);
                    send_ray(o, d, e, acc);
                    if (acc < 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL b2b_accept: ray %0d got no accept want accept", i);
                    end
                end
            end
            begin
                for (int k = 0; k < 4000 && got < 10; k++) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid === 1'b1 && out_ready) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL b2b_result: got extra output inv=%h want none", inv_ray_dir);
                        end else begin
                            r = exp_q.pop_front();
                            if ({ray_orig, inv_ray_dir, div_by_zero} !== {r.orig, r.inv, r.dbz}) begin
                                n_err++;
                                $display("FAIL b2b_result: #%0d got orig=%h inv=%h dbz=%b want orig=%h inv=%h dbz=%b",
                                         got, ray_orig, inv_ray_dir, div_by_zero, r.orig, r.inv, r.dbz);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        n_vec++;
        if (got != 10) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results want 10", got);
        end
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: got valid=%b pending=%0d want valid=0 pending=0",
                     out_valid, exp_q.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        ray_orig_in = '0;
        ray_dir_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_axis();
        test_mixed();
        test_min_neg();
        test_all_zero();
        test_reset_mid_div();
        test_backpressure();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
